// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: two-port round-robin arbiter in front of the
// single-ported data memory, with range checks and completion pulses.
module d_mem_arbiter #(
    parameter int unsigned MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    localparam logic [31:0] LIMIT = MEM_SIZE;

    logic        last;
    logic        elig0;
    logic        elig1;
    logic        nxt_gnt0;
    logic        nxt_gnt1;
    logic        nxt_last;
    logic        busy;
    logic        sel_we;
    logic        inrange;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // grant, completion and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            last   <= 1'b1;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            gnt0  <= nxt_gnt0;
            gnt1  <= nxt_gnt1;
            last  <= nxt_last;
            done0 <= gnt0;
            done1 <= gnt1;
            err0  <= gnt0 & ~inrange;
            err1  <= gnt1 & ~inrange;
            if (gnt0 & mem_memRead) begin
                rdata0 <= mem_readData;
            end
            if (gnt1 & mem_memRead) begin
                rdata1 <= mem_readData;
            end
        end
    end

    // round-robin pick among ports not already in service or acknowledge
    always_comb begin
        elig0    = req0 & ~gnt0 & ~done0;
        elig1    = req1 & ~gnt1 & ~done1;
        nxt_gnt0 = 1'b0;
        nxt_gnt1 = 1'b0;
        nxt_last = last;
        unique case (1'b1)
            elig0 & elig1: begin
                nxt_gnt0 = last;
                nxt_gnt1 = ~last;
                nxt_last = ~last;
            end
            elig0 & ~elig1: begin
                nxt_gnt0 = 1'b1;
                nxt_last = 1'b0;
            end
            ~elig0 & elig1: begin
                nxt_gnt1 = 1'b1;
                nxt_last = 1'b1;
            end
            default: begin
                nxt_gnt0 = 1'b0;
                nxt_gnt1 = 1'b0;
            end
        endcase
    end

    // route the owner's request to the memory, gated by the range check
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (gnt0) begin
            sel_addr  = addr0;
            sel_wdata = wdata0;
            sel_we    = we0;
        end else if (gnt1) begin
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_we    = we1;
        end
        busy          = gnt0 | gnt1;
        inrange       = busy & (sel_addr < LIMIT);
        mem_address   = sel_addr;
        mem_writeData = sel_wdata;
        mem_memWrite  = sel_we & inrange & ~rst;
        mem_memRead   = ~sel_we & inrange;
    end

endmodule
